// File: rtl/irq_debouncer.sv
// irq_debouncer: per-line interrupt conditioner.
// Each of the 2**IRQ_NUM_POW raw lines is synchronised into clk_i through a
// SYNC_STAGES-deep flop chain, then filtered by a stability counter: the
// debounced level only follows the synchronised level once the new value has
// persisted for DEBOUNCE_CYCLES consecutive cycles. One-cycle rise/fall strobes
// accompany every change of the debounced level. All outputs are registered.
// Optional build macro IRQ_DEBOUNCER_POLARITY_EN adds irq_pol_bi, a per-line
// polarity select (1 = active-low line) applied ahead of the synchroniser.
module irq_debouncer #(
    parameter int IRQ_NUM_POW     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [(2**IRQ_NUM_POW)-1:0]   irq_raw_bi,
`ifdef IRQ_DEBOUNCER_POLARITY_EN
    input  logic [(2**IRQ_NUM_POW)-1:0]   irq_pol_bi,
`endif
    output logic [(2**IRQ_NUM_POW)-1:0]   irq_debounced_bo,
    output logic [(2**IRQ_NUM_POW)-1:0]   irq_rise_bo,
    output logic [(2**IRQ_NUM_POW)-1:0]   irq_fall_bo
);

    localparam int N  = 2**IRQ_NUM_POW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which the next pending cycle commits the new level.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        LINE_STABLE  = 1'b0,
        LINE_PENDING = 1'b1
    } line_state_e;

    logic [N-1:0]  raw_in_s;
    logic [N-1:0]  sync_r [SYNC_STAGES];
    logic [N-1:0]  sync_last_s;
    logic [CW-1:0] cnt_r [N];
    logic [CW-1:0] cnt_nxt_s [N];
    line_state_e   line_state_s [N];
    logic [N-1:0]  deb_nxt_s;
    logic [N-1:0]  rise_nxt_s;
    logic [N-1:0]  fall_nxt_s;

`ifdef IRQ_DEBOUNCER_POLARITY_EN
    // Active-low lines are inverted before synchronisation so everything downstream is active-high.
    assign raw_in_s = irq_raw_bi ^ irq_pol_bi;
`else
    assign raw_in_s = irq_raw_bi;
`endif

    assign sync_last_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain bringing the asynchronous lines into clk_i.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                sync_r[st] <= {N{1'b0}};
            end
        end else begin
            sync_r[0] <= raw_in_s;
            for (int st = 1; st < SYNC_STAGES; st++) begin
                sync_r[st] <= sync_r[st-1];
            end
        end
    end

    // Per-line stability filter: count pending cycles, commit the level and strobe on the last one.
    always_comb begin
        deb_nxt_s  = irq_debounced_bo;
        rise_nxt_s = {N{1'b0}};
        fall_nxt_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt_nxt_s[i]    = {CW{1'b0}};
            line_state_s[i] = (sync_last_s[i] != irq_debounced_bo[i]) ? LINE_PENDING : LINE_STABLE;
            case (line_state_s[i])
                LINE_STABLE: begin
                    // A return to the debounced level discards any partial count (glitch rejection).
                    cnt_nxt_s[i] = {CW{1'b0}};
                end
                LINE_PENDING: begin
                    if (cnt_r[i] == CNT_LAST) begin
                        cnt_nxt_s[i]  = {CW{1'b0}};
                        deb_nxt_s[i]  = sync_last_s[i];
                        rise_nxt_s[i] = sync_last_s[i];
                        fall_nxt_s[i] = ~sync_last_s[i];
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
                    end
                end
                default: begin
                    cnt_nxt_s[i] = {CW{1'b0}};
                end
            endcase
        end
    end

    // Stability counters; reset discards any count in progress.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Registered debounced level and one-cycle edge strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            irq_debounced_bo <= {N{1'b0}};
            irq_rise_bo      <= {N{1'b0}};
            irq_fall_bo      <= {N{1'b0}};
        end else begin
            irq_debounced_bo <= deb_nxt_s;
            irq_rise_bo      <= rise_nxt_s;
            irq_fall_bo      <= fall_nxt_s;
        end
    end

endmodule

// File: tb/tb_irq_debouncer.sv
// Self-checking bench for irq_debouncer (16 lines, 2 sync stages, 4-cycle debounce).
// A vector table and hand-written corner sequences carry hand-derived
// expectations; every cycle is also compared against a queue-based model that
// states the rule directly: a line's debounced level flips at an edge when the
// synchronised level differed from it in each of the previous DEBOUNCE_CYCLES cycles.
module tb_irq_debouncer;

    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] raw;
    logic [15:0] deb;
    logic [15:0] rise;
    logic [15:0] fall;
`ifdef IRQ_DEBOUNCER_POLARITY_EN
    logic [15:0] pol = 16'h0000;
`endif

    int checks   = 0;
    int failures = 0;

    irq_debouncer #(
        .IRQ_NUM_POW     (4),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .irq_raw_bi       (raw),
`ifdef IRQ_DEBOUNCER_POLARITY_EN
        .irq_pol_bi       (pol),
`endif
        .irq_debounced_bo (deb),
        .irq_rise_bo      (rise),
        .irq_fall_bo      (fall)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [15:0] m_deb  = 16'h0000;
    logic [15:0] m_rise = 16'h0000;
    logic [15:0] m_fall = 16'h0000;
    logic [15:0] raw_q[$];   // raw samples of the last S edges (oldest first)
    logic [15:0] s_q[$];     // synchronised level of the last D cycles (oldest first)

    typedef struct {
        logic        rst;
        logic [15:0] raw;
        logic [15:0] deb;
        logic [15:0] rise;
        logic [15:0] fall;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [15:0] rv);
        logic [15:0] prev;
        logic        all_other;
        if (!r) begin
            m_deb = 16'h0000; m_rise = 16'h0000; m_fall = 16'h0000;
            raw_q.delete(); s_q.delete();
            for (int k = 0; k < S; k++) raw_q.push_back(16'h0000);
            for (int k = 0; k < D; k++) s_q.push_back(16'h0000);
        end else begin
            prev = m_deb;
            for (int i = 0; i < 16; i++) begin
                all_other = 1'b1;
                foreach (s_q[j]) if (s_q[j][i] == prev[i]) all_other = 1'b0;
                if (all_other) m_deb[i] = ~prev[i];
            end
            m_rise = m_deb & ~prev;
            m_fall = ~m_deb & prev;
            raw_q.push_back(rv);
            void'(raw_q.pop_front());
            s_q.push_back(raw_q[0]);
            void'(s_q.pop_front());
        end
    endtask

    int cyc = 0;

    // Drive one edge, advance the model, compare all outputs with it.
    task automatic step(input logic r, input logic [15:0] rv);
        @(negedge clk);
        rst_i = r;
        raw   = rv;
        @(posedge clk);
        #1;
        model_edge(r, rv);
        chk("model_deb",  cyc, deb,  m_deb);
        chk("model_rise", cyc, rise, m_rise);
        chk("model_fall", cyc, fall, m_fall);
        cyc++;
    endtask

    task automatic add(input logic r, input logic [15:0] rv, input logic [15:0] d,
                       input logic [15:0] ri, input logic [15:0] fa);
        vec_t v;
        v.rst = r; v.raw = rv; v.deb = d; v.rise = ri; v.fall = fa;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] rv;
        rst_i = 1'b0;
        raw   = 16'hFFFF;

        // Reset held 3 cycles with all lines high, then release.
        for (int k = 0; k < 3; k++) add(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 5; k++) add(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // Clean assert of line 3: output follows 5 edges after the first sample.
        for (int k = 0; k < 5; k++) add(1'b1, 16'h0008, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 16'h0008, 16'h0008, 16'h0008, 16'h0000);
        add(1'b1, 16'h0008, 16'h0008, 16'h0000, 16'h0000);
        add(1'b1, 16'h0008, 16'h0008, 16'h0000, 16'h0000);
        // Lines 0 and 15 rise together.
        for (int k = 0; k < 5; k++) add(1'b1, 16'h8009, 16'h0008, 16'h0000, 16'h0000);
        add(1'b1, 16'h8009, 16'h8009, 16'h8001, 16'h0000);
        add(1'b1, 16'h8009, 16'h8009, 16'h0000, 16'h0000);
        // Line 15 deasserts.
        for (int k = 0; k < 5; k++) add(1'b1, 16'h0009, 16'h8009, 16'h0000, 16'h0000);
        add(1'b1, 16'h0009, 16'h0009, 16'h0000, 16'h8000);
        add(1'b1, 16'h0009, 16'h0009, 16'h0000, 16'h0000);

        foreach (tbl[t]) begin
            step(tbl[t].rst, tbl[t].raw);
            chk("tbl_deb",  t, deb,  tbl[t].deb);
            chk("tbl_rise", t, rise, tbl[t].rise);
            chk("tbl_fall", t, fall, tbl[t].fall);
        end

        // Clean slate for the corner sequences.
        step(1'b0, 16'h0000);
        for (int k = 0; k < 4; k++) step(1'b1, 16'h0000);
        chk("clean_slate", 0, deb | rise | fall, 16'h0000);

        // Glitch: line 0 high for D-1 cycles only must never reach the output.
        for (int k = 0; k < 11; k++) begin
            step(1'b1, (k < 3) ? 16'h0001 : 16'h0000);
            chk("glitch", k, (deb | rise | fall) & 16'h0001, 16'h0000);
        end

        // Deassert: line 5 goes high, then drops; fall exactly 5 edges later.
        for (int k = 0; k < 8; k++) step(1'b1, 16'h0020);
        chk("deassert_pre", 0, deb, 16'h0020);
        for (int j = 0; j < 7; j++) begin
            step(1'b1, 16'h0000);
            chk("deassert_deb",  j, deb  & 16'h0020, (j < 5)  ? 16'h0020 : 16'h0000);
            chk("deassert_fall", j, fall & 16'h0020, (j == 5) ? 16'h0020 : 16'h0000);
        end

        // Reset mid-count: line 2 partial count is discarded.
        step(1'b1, 16'h0004);
        step(1'b1, 16'h0004);
        step(1'b0, 16'h0004);
        chk("midcount_reset", 0, deb | rise | fall, 16'h0000);
        for (int j = 0; j < 7; j++) begin
            step(1'b1, 16'h0004);
            chk("midcount_deb",  j, deb  & 16'h0004, (j >= 5) ? 16'h0004 : 16'h0000);
            chk("midcount_rise", j, rise & 16'h0004, (j == 5) ? 16'h0004 : 16'h0000);
        end

        // Randomised traffic: per-line toggles with ~1/6 probability, rare resets.
        rv = 16'h0000;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 5) == 0) rv[i] = ~rv[i];
            end
            step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_debouncer.md
Name: irq_debouncer

Overview:
- Per-line interrupt conditioner upstream of the processor tile.
- Synchronises 2**IRQ_NUM_POW asynchronous raw interrupt lines into clk_i.
- Filters glitches with a per-line stability counter.
- Outputs the debounced level vector, which drives the tile's irq_debounced_bi, plus one-cycle rising-edge strobes for SFR status or pending-capture logic.

Parameters:
- IRQ_NUM_POW, 4, log2 of line count; N = 2**IRQ_NUM_POW lines.
- SYNC_STAGES, 2, synchroniser flop depth per line; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive synchronised cycles of a new level required before the output follows; legal range 1..65535.

Ports:
- clk_i  input  1  sole clock.
- rst_i  input  1  reset, synchronous, active-low (0 = reset, sampled on rising clk_i).
- irq_raw_bi  input  N  raw asynchronous interrupt lines, active-high.
- irq_debounced_bo  output  N  filtered level per line, registered.
- irq_rise_bo  output  N  one-cycle pulse when the matching irq_debounced_bo bit goes 0->1, registered.
- irq_fall_bo  output  N  one-cycle pulse when the matching irq_debounced_bo bit goes 1->0, registered.

Behaviour:
- Reset (rst_i==0 at a clk_i edge):
  - All synchroniser flops, counters, irq_debounced_bo, irq_rise_bo and irq_fall_bo go to 0.
  - Reset mid-count discards the partial count.
  - No pulse is emitted on entering or leaving reset.
- Per line i, all lines fully independent:
  - sync[i]: SYNC_STAGES-deep flop chain on irq_raw_bi[i]; last stage = s.
  - cnt[i]: width $clog2(DEBOUNCE_CYCLES+1), unsigned, never wraps.
- State per line: STABLE (s == debounced) / PENDING (s != debounced).
  - STABLE: cnt <= 0.
  - PENDING and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - PENDING and cnt == DEBOUNCE_CYCLES-1: debounced <= s; cnt <= 0; the matching rise or fall bit <= 1 in the same edge.
  - Any cycle where s returns to the debounced value while PENDING clears cnt; no output change, no pulse. This is glitch rejection.
- Pulse outputs:
  - Default 0 each cycle unless set by a transition as above.
  - Pulse is high exactly in the cycle debounced first shows the new value.
- Latency:
  - Raw level changes and stays stable from edge k.
  - s reflects it at edge k+SYNC_STAGES.
  - irq_debounced_bo changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Fixed latency = SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles.
- DEBOUNCE_CYCLES==1: output follows s with one register of delay and no filtering.
- Simultaneous transitions on several lines are handled in the same cycle, each pulsing independently.
- Raw input toggling faster than DEBOUNCE_CYCLES: output holds its last stable value indefinitely.
- No combinational path from any input to any output.

Optional Feature:
- Macro: IRQ_DEBOUNCER_POLARITY_EN.
- Defined:
  - Extra port irq_pol_bi, input, N bits, quasi-static.
  - Bit=1 means line i is active-low.
  - The raw bit is XORed with irq_pol_bi[i] before the first synchroniser flop, so outputs stay active-high.
  - A polarity change is treated as an ordinary input change and is filtered normally.
- Undefined: port absent; all lines active-high.

Test Plan:
- Reset: rst_i=0 for 3 cycles with irq_raw_bi=16'hFFFF -> all outputs 0 during reset and on the first cycle after release.
- Clean assert (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): raw[3] 0->1 at edge 10 and held -> irq_debounced_bo[3]=1 from edge 15; irq_rise_bo[3]=1 only during the cycle after edge 15; other bits 0.
- Glitch: raw[0] high for 3 cycles then low, DEBOUNCE_CYCLES=4 -> irq_debounced_bo[0] stays 0; no rise or fall pulse.
- Deassert: line 5 debounced high, raw[5] drops and is held -> irq_debounced_bo[5]=0 after exactly 5 cycles; irq_fall_bo[5] single pulse.
- Simultaneous: raw 16'h0000 -> 16'h8001 at one edge -> bits 0 and 15 rise in the same cycle; irq_rise_bo=16'h8001 for one cycle.
- Reset mid-count: raw[2] high for 2 cycles, rst_i=0 for 1 cycle, raw kept high -> debounced[2] rises 5 cycles after reset release, not earlier.
